// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder built around a single 1-bit full-adder cell.
// A start pulse (accepted in IDLE or DONE) latches A, B and Cin. One bit pair
// per clock is then fed LSB first into the full adder. The carry circulates
// through a carry flip-flop, and each sum bit is shifted into the MSB of an
// internal result register. After WIDTH cycles the full result is copied to
// Sum/Cout and done pulses for one cycle.
//
// {Cout, Sum} = A + B + Cin  (unsigned, modulo 2^(WIDTH+1))
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request; sampled only when not busy
//   A      in   WIDTH  operand A, sampled with start
//   B      in   WIDTH  operand B, sampled with start
//   Cin    in   1      carry-in, sampled with start
//   busy   out  1      high while a serial add is in progress
//   done   out  1      one-cycle completion pulse
//   Sum    out  WIDTH  registered result, held between operations
//   Cout   out  1      registered final carry, held between operations
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // The single full-adder cell.
    logic fa_sum;
    logic fa_carry;
    logic last_bit;

    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                // Sum bits enter at the MSB so that after WIDTH shifts
                // bit 0 has arrived at the LSB.
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_carry;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // Publish including this cycle's bit, which is not in
                    // res_q yet.
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Decoded from the registered state, so both are glitch-free and
    // mutually exclusive by construction.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;

    int tests = 0;
    int fails = 0;

    // Reference model state: the result currently expected on Sum/Cout.
    logic [W-1:0] exp_sum;
    logic         exp_cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one add from the current (IDLE or DONE) cycle and returns just after
    // the completion edge, i.e. while the DUT sits in its DONE cycle.
    // mode 0: single start pulse
    // mode 1: extra start pulse with other operands sampled at edge k+3
    // mode 2: start held high through the whole run
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input int mode);
        logic [W:0] full;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        A     = a;
        B     = b;
        Cin   = c;
        start = 1'b1;
        tick();                               // edge k
        for (int i = 0; i < W; i++) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("sum_hold", Sum, exp_sum);
            chk("cout_hold", Cout, exp_cout);
            if (mode == 1 && i == 2) begin
                start = 1'b1;
                A     = 8'hAA;
                B     = 8'h55;
            end else if (mode == 2) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();                           // edge k+i+1
        end
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("sum_result", Sum, exp_sum);
        chk("cout_result", Cout, exp_cout);
        $display("[TB] add A=%02h B=%02h Cin=%0d -> Sum=%02h Cout=%0d (exp %02h %0d)",
                 a, b, c, Sum, Cout, exp_sum, exp_cout);
    endtask

    // Leave the DONE cycle with start low and confirm the pulse ends.
    task automatic finish_idle(input int cycles);
        start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk("done_low", done, 0);
            chk("busy_idle", busy, 0);
            chk("sum_idle", Sum, exp_sum);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);

        // Directed cases
        do_add(8'h5A, 8'h3C, 1'b0, 0);
        chk("basic_sum", Sum, 8'h96);
        finish_idle(2);
        do_add(8'hFF, 8'h01, 1'b0, 0);
        chk("ripple_sum", {Cout, Sum}, 9'h100);
        finish_idle(1);
        do_add(8'hFF, 8'hFF, 1'b1, 0);
        chk("max_sum", {Cout, Sum}, 9'h1FF);
        finish_idle(1);

        // Start pulse while busy is ignored; exactly one done pulse.
        do_add(8'h10, 8'h20, 1'b0, 1);
        chk("busy_ign_sum", {Cout, Sum}, 9'h030);
        finish_idle(W + 2);

        // Back-to-back: second start sampled at the DONE cycle edge.
        do_add(8'h01, 8'h02, 1'b0, 2);
        chk("b2b_first", Sum, 8'h03);
        do_add(8'h80, 8'h80, 1'b0, 0);
        chk("b2b_second", {Cout, Sum}, 9'h100);
        finish_idle(1);

        // Asynchronous reset in the middle of a run.
        A     = 8'h33;
        B     = 8'h44;
        Cin   = 1'b1;
        start = 1'b1;
        tick();                               // edge k
        start = 1'b0;
        repeat (4) tick();                    // past edge k+4
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;                        // between clock edges
        #1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", Sum, 0);
        chk("arst_cout", Cout, 0);
        tick();
        rst = 1'b0;
        $display("[TB] async reset mid-run: busy=%0d done=%0d Sum=%02h Cout=%0d",
                 busy, done, Sum, Cout);
        finish_idle(W + 2);
        do_add(8'hC3, 8'h5E, 1'b1, 0);
        finish_idle(1);

        // Randomized adds, some back-to-back, against the arithmetic model.
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            do_add(ra, rb, rc, ($urandom_range(0, 3) == 0) ? 1 : 0);
            if ($urandom_range(0, 1) == 1)
                finish_idle(1 + $urandom_range(0, 2));
        end
        finish_idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around a single 1-bit full-adder datapath (sum = a^b^c, carry = majority(a,b,c)). It sits directly upstream of that full-adder cell. It latches two operands on a start pulse and feeds one bit pair per clock, LSB first, into the cell. It feeds the cell's carry back through a carry flip-flop and shifts the cell's sum bit into a result register. Final Sum/Cout are presented with a one-cycle done pulse, trading latency for area against a parallel ripple adder.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, asynchronous, active-high.
- start  input  1  request; sampled only when not busy.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- Cin  input  1  carry-in; sampled with start.
- busy  output  1  high while a serial add is in progress.
- done  output  1  single-cycle completion pulse.
- Sum  output  WIDTH  registered result; held between operations.
- Cout  output  1  registered final carry; held between operations.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing bits.
  - DONE: one-cycle completion state.
- IDLE and DONE, start=1:
  - Load shift registers with A and B, load the carry FF with Cin, clear the bit counter.
  - busy<=1, go to RUN.
- IDLE and DONE, start=0:
  - IDLE stays in IDLE.
  - DONE returns to IDLE.
- RUN, each cycle:
  - The full-adder inputs are the operand LSBs and the carry FF.
  - Its sum bit shifts into the MSB of the internal result register (right shift).
  - Its carry bit loads the carry FF.
  - The operand registers shift right and the counter increments.
- RUN, when the counter reaches WIDTH-1 (last bit):
  - Sum<=final result register contents, including this cycle's bit.
  - Cout<=this cycle's carry.
  - busy<=0, done<=1, go to DONE.
- start is ignored while in RUN. Operands are not re-sampled.
- Sum/Cout change only at completion and keep the previous result during RUN.
- Arithmetic is unsigned: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1).
- Counter width: clog2(WIDTH). No other wrap: the counter is cleared on every load.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, Sum=0, Cout=0.
  - Internal shift registers, carry FF and counter are all 0.
- Reset mid-RUN: the operation aborts immediately, with no done pulse. Outputs return to reset values.
- Let start be sampled high at rising edge k:
  - busy is high from after edge k through edge k+WIDTH.
  - Bit i (i=0..WIDTH-1) is computed in the cycle following edge k+i and registered at edge k+i+1.
  - Sum, Cout and done update at edge k+WIDTH.
  - done is high for exactly one cycle, edges k+WIDTH..k+WIDTH+1.
- Latency is WIDTH cycles from start edge to valid result.
- Back-to-back: start high during the DONE cycle is accepted at edge k+WIDTH+1. Throughput is one add per WIDTH+1 cycles.
- busy and done are never high in the same cycle.

## Test plan
- Basic add: WIDTH=8, A=8'h5A, B=8'h3C, Cin=0, start 1 cycle -> at edge k+8 Sum=8'h96, Cout=0, done high 1 cycle, busy high 8 cycles.
- Full carry ripple: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1.
- Maximum operands: A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
- Start during busy:
  - Stimulus: start A=8'h10, B=8'h20, then pulse start with A=8'hAA, B=8'h55 at edge k+3.
  - Response: result is Sum=8'h30, Cout=0, and exactly one done pulse.
- Back-to-back:
  - Stimulus: start A=1, B=2 held through the done cycle, with A=8'h80, B=8'h80 presented during the done cycle.
  - Response: first result Sum=8'h03. Second done at edge k+17 with Sum=8'h00, Cout=1. Sum holds 8'h03 throughout the second RUN.
- Reset mid-operation: assert rst asynchronously at k+4 during an add -> busy, done, Sum and Cout go to 0 immediately. No done pulse follows. A subsequent add completes correctly.
